// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit beside the Ex-stage ALU: one result bit
// per cycle, with a single-cycle path for divide-by-zero and signed overflow.
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            Clk,
    input  logic            RstN,
    input  logic            StartIn,
    input  logic [6:0]      OpCodeIn,
    input  logic [2:0]      Funct3In,
    input  logic [6:0]      Funct7In,
    input  logic [XLEN-1:0] Rs1ReadDataIn,
    input  logic [XLEN-1:0] Rs2ReadDataIn,
    input  logic [4:0]      RdAddrIn,
    input  logic            FlushIn,
    output logic [XLEN-1:0] ResultOut,
    output logic [4:0]      RdAddrOut,
    output logic            RdWriteEnableOut,
    output logic            DoneOut,
    output logic            BusyOut,
    output logic            HoldFlagToCtrl
);
    localparam int         CW       = $clog2(XLEN) + 1;
    localparam int         DW       = 2 * XLEN;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_REG32 = 7'b0111011;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    state_e          r_state, w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;

    logic [2:0]      r_funct3;
    logic            r_word, r_neg_q, r_neg_r;
    logic [DW-1:0]   r_prod, r_mcand;
    logic [XLEN-1:0] r_opb, r_quo, r_rem;

    // ---------------- decode and operand preparation ----------------
    logic            w_is_word_op, w_is_muldiv, w_accept, w_fast;
    logic            w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_div0, w_ovf;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_int_min;
    logic [XLEN-1:0] w_fast_raw, w_fast_res;

    assign w_is_word_op = (XLEN == 64) && (OpCodeIn == OP_REG32);
    assign w_is_muldiv  = (Funct7In == 7'b0000001) &&
                          ((OpCodeIn == OP_REG) ||
                           (w_is_word_op && ((Funct3In == F3_MUL) || Funct3In[2])));
    assign w_accept     = (r_state == S_IDLE) && StartIn && w_is_muldiv && !FlushIn;

    assign w_sgn_a = (Funct3In == F3_MULH) || (Funct3In == F3_MULHSU) ||
                     (Funct3In == F3_DIV)  || (Funct3In == F3_REM);
    assign w_sgn_b = (Funct3In == F3_MULH) || (Funct3In == F3_DIV) || (Funct3In == F3_REM);

    assign w_a_ext = !w_is_word_op ? Rs1ReadDataIn :
                     (w_sgn_a ? sext32(Rs1ReadDataIn[31:0]) : zext32(Rs1ReadDataIn[31:0]));
    assign w_b_ext = !w_is_word_op ? Rs2ReadDataIn :
                     (w_sgn_b ? sext32(Rs2ReadDataIn[31:0]) : zext32(Rs2ReadDataIn[31:0]));

    assign w_neg_a = w_sgn_a && w_a_ext[XLEN-1];
    assign w_neg_b = w_sgn_b && w_b_ext[XLEN-1];
    assign w_mag_a = w_neg_a ? -w_a_ext : w_a_ext;
    assign w_mag_b = w_neg_b ? -w_b_ext : w_b_ext;

    // Most-negative value of the operation width, as it appears after extension.
    assign w_int_min = w_is_word_op ? ~zext32(32'h7FFF_FFFF) : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div0    = Funct3In[2] && (w_b_ext == '0);
    assign w_ovf     = Funct3In[2] && w_sgn_a && (w_a_ext == w_int_min) && (w_b_ext == '1);
    assign w_fast    = w_div0 || w_ovf;

    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign w_fast_raw = Funct3In[1] ? (w_div0 ? w_a_ext : '0)
                                    : (w_div0 ? '1 : w_a_ext);
    assign w_fast_res = w_is_word_op ? sext32(w_fast_raw[31:0]) : w_fast_raw;

    // ---------------- one iteration of multiply / divide ----------------
    logic [DW-1:0]   w_prod_nxt, w_prod_sgn;
    logic [XLEN:0]   w_rem_shl, w_trial;
    logic            w_fits;
    logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_raw, w_final;

    assign w_prod_nxt = r_opb[0] ? (r_prod + r_mcand) : r_prod;
    assign w_rem_shl  = {r_rem, r_quo[XLEN-1]};
    assign w_trial    = w_rem_shl - {1'b0, r_opb};
    assign w_fits     = !w_trial[XLEN];
    assign w_rem_nxt  = w_fits ? w_trial[XLEN-1:0] : w_rem_shl[XLEN-1:0];
    assign w_quo_nxt  = {r_quo[XLEN-2:0], w_fits};
    assign w_prod_sgn = r_neg_q ? -w_prod_nxt : w_prod_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_raw = '0;
        case (r_funct3)
            3'b000:                 w_raw = w_prod_sgn[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_raw = w_prod_sgn[DW-1:XLEN];
            3'b100, 3'b101:         w_raw = r_neg_q ? -w_quo_nxt : w_quo_nxt;
            default:                w_raw = r_neg_r ? -w_rem_nxt : w_rem_nxt;
        endcase
    end

    assign w_final = r_word ? sext32(w_raw[31:0]) : w_raw;

    // ---------------- control FSM ----------------
    always_ff @(posedge Clk) begin
        if (!RstN) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_CALC;
            S_CALC: begin
                if (FlushIn)                 w_state_nxt = S_IDLE;
                else if (r_count == CW'(1))  w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            r_count  <= '0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (w_accept) begin
            r_rd    <= RdAddrIn;
            r_count <= w_fast ? '0 : (w_is_word_op ? CW'(32) : CW'(XLEN));
            if (w_fast) r_result <= w_fast_res;
        end else if (r_state == S_CALC) begin
            r_count <= FlushIn ? '0 : (r_count - CW'(1));
            if (!FlushIn && (r_count == CW'(1))) r_result <= w_final;
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge Clk) begin
        if (w_accept) begin
            r_funct3 <= Funct3In;
            r_word   <= w_is_word_op;
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_prod   <= '0;
            r_mcand  <= DW'(w_mag_a);
            r_opb    <= w_mag_b;
            r_rem    <= '0;
            // Left-justify a word dividend so the next bit is always at the top.
            r_quo    <= w_is_word_op ? (w_mag_a << (XLEN - 32)) : w_mag_a;
        end else if (r_state == S_CALC) begin
            if (r_funct3[2]) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end else begin
                r_prod  <= w_prod_nxt;
                r_mcand <= r_mcand << 1;
                r_opb   <= r_opb >> 1;
            end
        end
    end

    assign ResultOut        = r_result;
    assign RdAddrOut        = r_rd;
    assign DoneOut          = (r_state == S_DONE);
    assign RdWriteEnableOut = DoneOut;
    assign BusyOut          = (r_state != S_IDLE);
    assign HoldFlagToCtrl   = w_accept || (r_state == S_CALC);

endmodule
